// File: rtl/mac_array_os.sv
// Output-stationary ROWS x COLS MAC array: bias/zero init, k_len outer-product beats,
// then a row-major drain with rounding shift, optional ReLU and saturation to DW bits.
module mac_array_os #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 24,
    parameter int KW   = 8,
    parameter int SW   = $clog2(AW),
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [KW-1:0]        k_len_i,
    input  logic                 bias_en_i,
    input  logic [COLS*AW-1:0]   bias_i,
    input  logic [SW-1:0]        shift_i,
    input  logic                 relu_en_i,
    output logic                 busy_o,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [ROWS*DW-1:0]   op_x_i,
    input  logic [COLS*DW-1:0]   op_w_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DW-1:0]        out_data_o,
    output logic [RIW-1:0]       out_row_o,
    output logic [CIW-1:0]       out_col_o,
    output logic                 out_last_o,
    output logic [1:0]           dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the presenter holds its payload stable until that edge.

    localparam int PW = 2*DW + 1;
    localparam logic signed [AW:0] ONE     = (AW+1)'(1);
    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = -SAT_MAX - ONE;
    localparam logic [DW-1:0]      OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]      OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_READ} state_t;

    state_t          state;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   cnt;
    logic [SW-1:0]   shift_q;
    logic            relu_q;
    logic [RIW-1:0]  row_q;
    logic [CIW-1:0]  col_q;

    logic signed [AW-1:0] acc   [ROWS][COLS];
    logic signed [PW-1:0] p_q   [ROWS][COLS];
    logic signed [PW-1:0] prod  [ROWS][COLS];
    logic                 p_valid;

    logic start_take;
    logic beat_acc;

    assign start_take  = (state == S_IDLE) && start_i;
    assign op_ready_o  = (state == S_ACCUM) && (cnt < k_len_q);
    assign beat_acc    = op_valid_i && op_ready_o;
    assign busy_o      = (state != S_IDLE);
    assign out_valid_o = (state == S_READ);
    assign out_row_o   = row_q;
    assign out_col_o   = col_q;
    assign out_last_o  = (state == S_READ) && (row_q == RIW'(ROWS-1)) && (col_q == CIW'(COLS-1));
    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            k_len_q <= '0;
            cnt     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        k_len_q <= k_len_i;
                        shift_q <= shift_i;
                        relu_q  <= relu_en_i;
                        cnt     <= '0;
                        state   <= (k_len_i == '0) ? S_DRAIN : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (beat_acc) begin
                        cnt <= cnt + KW'(1);
                        if (cnt == k_len_q - KW'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    row_q <= '0;
                    col_q <= '0;
                    state <= S_READ;
                end
                S_READ: begin
                    if (out_ready_i) begin
                        if (col_q == CIW'(COLS-1)) begin
                            col_q <= '0;
                            if (row_q == RIW'(ROWS-1)) begin
                                row_q <= '0;
                                state <= S_IDLE;
                            end else begin
                                row_q <= row_q + RIW'(1);
                            end
                        end else begin
                            col_q <= col_q + CIW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Activations are unsigned, so they get a zero sign bit before the signed multiply.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod[i][j] = PW'($signed(op_w_i[j*DW +: DW])) *
                             $signed(PW'({1'b0, op_x_i[i*DW +: DW]}));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_valid <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    p_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else begin
            p_valid <= beat_acc;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    if (beat_acc) p_q[i][j] <= prod[i][j];
                    if (start_take)
                        acc[i][j] <= bias_en_i ? $signed(bias_i[j*AW +: AW]) : '0;
                    else if (p_valid)
                        acc[i][j] <= acc[i][j] + {{(AW-PW){p_q[i][j][PW-1]}}, p_q[i][j]};
                end
            end
        end
    end

    logic signed [AW-1:0] acc_sel;
    logic signed [AW:0]   rnd;
    logic signed [AW:0]   q_sum;
    logic signed [AW:0]   q_shr;
    logic signed [AW:0]   q_rel;

    always_comb begin
        acc_sel = acc[row_q][col_q];
        rnd     = '0;
        if (shift_q != '0) rnd = ONE <<< (shift_q - SW'(1));
        q_sum = {acc_sel[AW-1], acc_sel} + rnd;
        q_shr = q_sum >>> shift_q;
        q_rel = (relu_q && q_shr[AW]) ? '0 : q_shr;
        if (q_rel > SAT_MAX)      out_data_o = OUT_MAX;
        else if (q_rel < SAT_MIN) out_data_o = OUT_MIN;
        else                      out_data_o = q_rel[DW-1:0];
    end

endmodule

// File: tb/tb_mac_array_os.sv
// Randomised and directed bench for mac_array_os; expected drain sequences come from a
// plain-arithmetic model pushed into a queue and popped by an output monitor.
module tb_mac_array_os;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int KW   = 8;
    localparam int SW   = 5;
    localparam int EW   = 1 + 2 + 2 + DW;

    logic               clk;
    logic               rstn;
    logic               start_i;
    logic [KW-1:0]      k_len_i;
    logic               bias_en_i;
    logic [COLS*AW-1:0] bias_i;
    logic [SW-1:0]      shift_i;
    logic               relu_en_i;
    logic               busy_o;
    logic               op_valid_i;
    logic               op_ready_o;
    logic [ROWS*DW-1:0] op_x_i;
    logic [COLS*DW-1:0] op_w_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DW-1:0]      out_data_o;
    logic [1:0]         out_row_o;
    logic [1:0]         out_col_o;
    logic               out_last_o;
    logic [1:0]         dbg_state_o;

    mac_array_os dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .k_len_i(k_len_i),
        .bias_en_i(bias_en_i), .bias_i(bias_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
        .busy_o(busy_o), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_x_i(op_x_i), .op_w_i(op_w_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_row_o(out_row_o),
        .out_col_o(out_col_o), .out_last_o(out_last_o), .dbg_state_o(dbg_state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    int bx[64][ROWS];
    int bw[64][COLS];
    int bias_v[COLS];
    bit rand_rdy = 0;
    bit bp_mode  = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: acc = bias + sum_t x*w wrapped to AW bits, then round/shift/relu/clamp.
    function automatic void push_model(input int k, input bit ben, input int sh, input bit rl);
        longint a, r;
        logic [DW-1:0] d;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                a = ben ? longint'(bias_v[j]) : 0;
                for (int t = 0; t < k; t++) a += longint'(bx[t][i]) * longint'(bw[t][j]);
                a = a & ((longint'(1) <<< AW) - 1);
                if (a >= (longint'(1) <<< (AW-1))) a -= (longint'(1) <<< AW);
                r = a;
                if (sh > 0) r += (longint'(1) <<< (sh - 1));
                r = r >>> sh;
                if (rl && r < 0) r = 0;
                if (r > 127) r = 127;
                if (r < -128) r = -128;
                d = DW'(r);
                exp_q.push_back({(i == ROWS-1 && j == COLS-1), 2'(i), 2'(j), d});
            end
        end
    endfunction

    // Ready driver; the backpressure test takes over out_ready_i through bp_mode.
    always @(posedge clk) begin
        #1;
        if (!bp_mode) out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [EW-1:0] got, held, e;
    bit held_v = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = 0;
        end else begin
            got = {out_last_o, out_row_o, out_col_o, out_data_o};
            if (held_v) begin
                check("stall_valid", out_valid_o, 1);
                check("stall_fields", got, held);
                held_v = 0;
            end
            if (out_valid_o) begin
                if (out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h required no output", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_elem", got, e);
                    end
                end else begin
                    held   = got;
                    held_v = 1;
                end
            end
        end
    end

    task automatic start_job(input int k, input bit ben, input int sh, input bit rl);
        k_len_i   = KW'(k);
        bias_en_i = ben;
        for (int j = 0; j < COLS; j++) bias_i[j*AW +: AW] = AW'(bias_v[j]);
        shift_i   = SW'(sh);
        relu_en_i = rl;
        start_i   = 1;
        push_model(k, ben, sh, rl);
        @(posedge clk); #1;
        start_i = 0;
        check("busy_rise", busy_o, 1);
    endtask

    // mode 0: contiguous, 1: valid every other cycle, 2: random gaps
    task automatic send_beats(input int k, input int mode);
        int sent = 0;
        int cyc  = 0;
        bit took;
        while (sent < k && cyc < 1000) begin
            case (mode)
                0: op_valid_i = 1;
                1: op_valid_i = (cyc % 2 == 0);
                default: op_valid_i = 1'($urandom_range(0, 1));
            endcase
            for (int i = 0; i < ROWS; i++) op_x_i[i*DW +: DW] = DW'(bx[sent][i]);
            for (int j = 0; j < COLS; j++) op_w_i[j*DW +: DW] = DW'(bw[sent][j]);
            @(negedge clk);
            took = op_valid_i && op_ready_o;
            @(posedge clk); #1;
            if (took) sent++;
            cyc++;
        end
        op_valid_i = 0;
        check("beats_sent", sent, k);
    endtask

    task automatic wait_done();
        int c = 0;
        while ((exp_q.size() != 0 || busy_o) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("job_in_budget", (c < 3000), 1);
        check("queue_drained", exp_q.size(), 0);
        check("busy_low_after", busy_o, 0);
    endtask

    task automatic fill_const(input int k, input int x, input int w);
        for (int t = 0; t < k; t++) begin
            for (int i = 0; i < ROWS; i++) bx[t][i] = x;
            for (int j = 0; j < COLS; j++) bw[t][j] = w;
        end
    endtask

    task automatic fill_rand(input int k);
        for (int t = 0; t < k; t++) begin
            for (int i = 0; i < ROWS; i++) bx[t][i] = int'($urandom_range(0, 255));
            for (int j = 0; j < COLS; j++) bw[t][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic zero_bias();
        for (int j = 0; j < COLS; j++) bias_v[j] = 0;
    endtask

    task automatic const_job(input int k, input int x, input int w, input int sh, input bit rl);
        fill_const(k, x, w);
        zero_bias();
        start_job(k, 0, sh, rl);
        send_beats(k, 0);
        check("drain_cycle_valid", out_valid_o, 0);
        @(posedge clk); #1;
        check("first_out_valid", out_valid_o, 1);
        wait_done();
    endtask

    initial begin
        int k, sh;
        bit found;
        rstn = 0; start_i = 0; k_len_i = '0; bias_en_i = 0; bias_i = '0; shift_i = '0;
        relu_en_i = 0; op_valid_i = 0; op_x_i = '0; op_w_i = '0; out_ready_i = 1;
        #23;
        check("rst_busy", busy_o, 0);
        check("rst_op_ready", op_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_row", out_row_o, 0);
        check("rst_out_col", out_col_o, 0);
        check("rst_out_last", out_last_o, 0);
        check("rst_state", dbg_state_o, 0);
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;

        // Bias only, k_len=0: DRAIN right after start, outputs in the second cycle.
        for (int j = 0; j < COLS; j++) bias_v[j] = 10 * j;
        start_job(0, 1, 0, 0);
        check("k0_drain_cycle", out_valid_o, 0);
        @(posedge clk); #1;
        check("k0_first_valid", out_valid_o, 1);
        wait_done();

        const_job(3, 2, -3, 0, 0);
        const_job(3, 2, -3, 0, 1);
        const_job(1, 255, 127, 9, 0);
        const_job(1, 255, 127, 7, 0);
        const_job(1, 255, -128, 8, 0);
        const_job(1, 255, -128, 4, 0);

        // Gapped valid; once all beats are in, extra valid beats must not be taken.
        fill_const(4, 1, 5);
        zero_bias();
        start_job(4, 0, 0, 0);
        send_beats(4, 1);
        op_valid_i = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_extra_ready", op_ready_o, 0);
            @(posedge clk); #1;
        end
        op_valid_i = 0;
        wait_done();

        // Backpressure held for 5 cycles on element (1,1).
        fill_rand(2);
        zero_bias();
        bp_mode = 1;
        out_ready_i = 1;
        start_job(2, 0, 3, 0);
        send_beats(2, 0);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (out_valid_o && out_row_o == 2'd1 && out_col_o == 2'd1) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("bp_reached_1_1", found, 1);
        out_ready_i = 0;
        repeat (5) begin @(posedge clk); #1; end
        check("bp_still_1_1", {out_row_o, out_col_o}, 4'b0101);
        out_ready_i = 1;
        bp_mode = 0;
        wait_done();

        // Reset in the middle of ACCUM aborts the job.
        fill_const(4, 3, 7);
        zero_bias();
        start_job(4, 0, 0, 0);
        send_beats(2, 0);
        rstn = 0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_op_ready", op_ready_o, 0);
        check("midrst_out_valid", out_valid_o, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        check("midrst_stays_idle", busy_o, 0);
        start_job(0, 0, 0, 0);
        wait_done();

        // Randomised jobs with random valid gaps and random output ready.
        rand_rdy = 1;
        for (int n = 0; n < 20; n++) begin
            k  = int'($urandom_range(0, 12));
            sh = int'($urandom_range(0, 16));
            fill_rand(k);
            for (int j = 0; j < COLS; j++) bias_v[j] = int'($urandom) >>> 8;
            start_job(k, 1'($urandom_range(0, 1)), sh, 1'($urandom_range(0, 1)));
            send_beats(k, 2);
            wait_done();
        end
        rand_rdy = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_array_os.md
# mac_array_os

Parametrised output-stationary MAC array for the scalar core's MLP datapath, generalising the fixed 8x8 systolic array. A ROWS x COLS grid of signed accumulators is initialised to zero or a per-column bias, then accumulates k_len outer-product beats under a valid/ready handshake. Results are drained one element per handshake in row-major order, each with round-to-nearest shift, optional ReLU and signed saturation to DW bits.

## Interface
- ROWS, 4, accumulator rows (batch samples)
- COLS, 4, accumulator columns (output neurons)
- DW, 8, operand and output width
- AW, 24, accumulator width (signed)
- KW, 8, width of k_len_i
- SW, $clog2(AW), width of shift_i
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a job; sampled only when busy_o=0
- k_len_i  in  KW  number of MAC beats in the job; latched on start
- bias_en_i  in  1  1: init acc[i][j]=sext(bias_i[j]); 0: init to 0; sampled on start
- bias_i  in  COLS*AW  signed per-column bias, column j at [j*AW +: AW]; sampled on start
- shift_i  in  SW  requantisation right shift; latched on start
- relu_en_i  in  1  clamp negative results to 0; latched on start
- busy_o  out  1  high in every state except IDLE
- op_valid_i  in  1  operand beat valid
- op_ready_o  out  1  array accepts a beat
- op_x_i  in  ROWS*DW  unsigned activations, row i at [i*DW +: DW]
- op_w_i  in  COLS*DW  signed weights, column j at [j*DW +: DW]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- out_data_o  out  DW  signed requantised result
- out_row_o  out  $clog2(ROWS)  row index of out_data_o
- out_col_o  out  $clog2(COLS)  column index of out_data_o
- out_last_o  out  1  high with the final element (ROWS-1, COLS-1)

## Operation
- FSM states: IDLE, ACCUM, DRAIN, READ.
- IDLE: on start_i, initialise accumulators, latch k_len/shift/relu, clear beat counter, go to ACCUM. start_i outside IDLE is ignored.
- ACCUM: op_ready_o = (beats accepted < k_len). A beat is accepted on op_valid_i & op_ready_o.
  - Stage 1 registers p[i][j] = $signed(w[j]) * $signed({1'b0, x[i]}), 2*DW+1 bits, plus a valid bit.
  - Stage 2 adds sext(p) to acc[i][j], wrapping modulo 2^AW.
  - When the accepted count reaches k_len, go to DRAIN. With k_len=0, go to DRAIN directly.
- DRAIN: one cycle so the last in-flight product lands in the accumulator, then go to READ with index 0.
- READ: out_valid_o=1. The output fields are driven from acc[out_row][out_col] and the latched config.
  - On out_valid_o & out_ready_i, advance the index row-major.
  - After the handshake with out_last_o=1, return to IDLE. Accumulators keep their values until the next start.
- Requantisation, computed in AW+1 bits:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
  - If relu, r = max(r, 0).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
- op_valid_i is ignored outside ACCUM. out_ready_i is ignored outside READ.

## Timing
- Reset values: busy_o=0, op_ready_o=0, out_valid_o=0, out_data_o=0, out_row_o=0, out_col_o=0, out_last_o=0. All accumulators and the pipeline are cleared and the FSM is in IDLE.
- busy_o rises the cycle after start_i is sampled.
- A beat accepted at edge n is in the accumulator after edge n+1.
- Last beat at edge n: DRAIN during cycle n+1, first out_valid_o in cycle n+2.
- k_len=0: start at edge s gives first out_valid_o in cycle s+2.
- Backpressure: while out_valid_o & !out_ready_i, all output fields are stable. No element is skipped or repeated.
- Full throughput: one beat per cycle in ACCUM and one result per cycle in READ.
- op_ready_o deasserts in the cycle after the k_len-th accept.
- Reset mid-job (any state) aborts immediately. Nothing resumes after release.

## Test plan
- Bias only: k_len=0, bias_en=1, bias[j]=10*j, shift=0, relu=0 -> 16 outputs, row-major, value 10*col; out_last_o only on (3,3); busy_o low afterwards.
- Basic MAC with ReLU: k_len=3, all x=2, all w=-3, bias off -> every output -18; repeated with relu=1 -> every output 0.
- Rounding and saturation with k_len=1, bias off:
  - x=255, w=127 (acc 32385): shift=9 -> 63; shift=7 -> 127 (saturated).
  - x=255, w=-128 (acc -32640): shift=8 -> -127; shift=4 -> -128 (saturated).
- Input gaps: k_len=4, op_valid_i toggled every cycle, x=1, w=5 -> all outputs 20 (same as a contiguous stream); op_ready_o low after the 4th accept, extra valid beats not consumed.
- Output backpressure: out_ready_i held low 5 cycles while index (1,1) is presented -> out_data_o/row/col stable; sequence continues at (1,2) with no loss or duplication.
- Reset mid-ACCUM: assert rstn low after 2 of 4 beats -> busy_o, op_ready_o, out_valid_o = 0; new job with k_len=0, bias off -> all 16 outputs 0.
